pc_unit: RTL and testbench

- Program-counter stage of the single-cycle MIPS core. Sits directly downstream of the instruction decoder.
- Owns the PC register and consumes the decoder's 3-bit PCSrc select, the ALU branch-compare bit and the instruction target fields to compute next PC.
- Also upstream of the decoder: latches the peripheral interrupt request and presents a gated IRQ to the decoder (suppressed in kernel mode, PC[31]=1).
- Produces the return address written to $k0 on interrupt/exception entry.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/pc_next_mux.sv | 41 ++++
 rtl/pc_unit.sv | 78 +++++++
 tb/tb_pc_unit.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the single-cycle MIPS core: next-PC select values and
// the kernel-space vector addresses. The decoder uses the same constants.
package cpu_pkg;

  localparam int unsigned PC_SRC_W = 3;

  typedef enum logic [PC_SRC_W-1:0] {
    PC_SEQ = 3'd0,
    PC_BR  = 3'd1,
    PC_J   = 3'd2,
    PC_JR  = 3'd3,
    PC_IRQ = 3'd4,
    PC_EXC = 3'd5
  } pc_src_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam logic [31:0] IRQ_VEC_DEF  = 32'h8000_0004;
  localparam logic [31:0] EXC_VEC_DEF  = 32'h8000_0008;

  // True for selects that redirect into a handler and so do not commit.
  function automatic logic is_entry(input logic [PC_SRC_W-1:0] sel);
    return sel[2];
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC selection and the $k0 save value for handler entry.
// Selects 6 and 7 fall through to the exception vector.
module pc_next_mux
  import cpu_pkg::*;
#(
  parameter logic [31:0] IRQ_VEC = IRQ_VEC_DEF,
  parameter logic [31:0] EXC_VEC = EXC_VEC_DEF
) (
  input  logic [31:0] pc,
  input  logic [31:0] pc_plus4,
  input  logic [2:0]  pc_src,
  input  logic        branch_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] target26,
  input  logic [31:0] rs_data,
  output logic [31:0] next_pc,
  output logic [31:0] save_pc
);

  logic [31:0] br_offset;
  logic [31:0] br_target;

  assign br_offset = {{14{imm16[15]}}, imm16, 2'b00};
  assign br_target = pc_plus4 + br_offset;

  // Only jr may change pc[31]; branch and jump splice the current kernel bit back in.
  always_comb begin
    next_pc = EXC_VEC;
    case (pc_src)
      PC_SEQ:  next_pc = pc_plus4;
      PC_BR:   next_pc = branch_taken ? {pc[31], br_target[30:0]} : pc_plus4;
      PC_J:    next_pc = {pc[31], pc_plus4[30:28], target26, 2'b00};
      PC_JR:   next_pc = rs_data;
      PC_IRQ:  next_pc = IRQ_VEC;
      default: next_pc = EXC_VEC;
    endcase
  end

  assign save_pc = (pc_src == PC_IRQ) ? pc : pc_plus4;

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage: holds PC, the latched interrupt request and the
// committed-instruction counter; gates the IRQ seen by the decoder.
module pc_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] IRQ_VEC  = IRQ_VEC_DEF,
  parameter logic [31:0] EXC_VEC  = EXC_VEC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [2:0]  pc_src,
  input  logic        branch_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] target26,
  input  logic [31:0] rs_data,
  input  logic        irq_in,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] save_pc,
  output logic        irq_out,
  output logic [31:0] instr_count
);

  logic [31:0] pc_q, pc_d;
  logic        irq_pending_q, irq_pending_d;
  logic [31:0] instr_count_q, instr_count_d;
  logic [31:0] next_pc;

  assign pc_plus4 = pc_q + 32'd4;

  pc_next_mux #(
    .IRQ_VEC (IRQ_VEC),
    .EXC_VEC (EXC_VEC)
  ) u_next (
    .pc           (pc_q),
    .pc_plus4     (pc_plus4),
    .pc_src       (pc_src),
    .branch_taken (branch_taken),
    .imm16        (imm16),
    .target26     (target26),
    .rs_data      (rs_data),
    .next_pc      (next_pc),
    .save_pc      (save_pc)
  );

  // Clearing on interrupt entry beats a simultaneous new request; a still-high
  // irq_in simply re-sets the bit on the following edge.
  always_comb begin
    pc_d          = pc_q;
    irq_pending_d = irq_pending_q;
    instr_count_d = instr_count_q;
    if (!stall) begin
      pc_d = next_pc;
      if (!is_entry(pc_src)) instr_count_d = instr_count_q + 32'd1;
    end
    if (!stall && pc_src == PC_IRQ) irq_pending_d = 1'b0;
    else if (irq_in)                irq_pending_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      irq_pending_q <= 1'b0;
      instr_count_q <= 32'd0;
    end else begin
      pc_q          <= pc_d;
      irq_pending_q <= irq_pending_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign pc          = pc_q;
  assign instr_count = instr_count_q;
  assign irq_out     = irq_pending_q & ~pc_q[31] & ~stall;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: hand-computed PC, counter, save_pc and IRQ values.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, irq_in;
  logic [2:0]  pc_src;
  logic [15:0] imm16;
  logic [25:0] target26;
  logic [31:0] rs_data;
  logic [31:0] pc, pc_plus4, save_pc, instr_count;
  logic        irq_out;

  int n_checks = 0;
  int n_fail   = 0;

  pc_unit dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .pc_src       (pc_src),
    .branch_taken (branch_taken),
    .imm16        (imm16),
    .target26     (target26),
    .rs_data      (rs_data),
    .irq_in       (irq_in),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .save_pc      (save_pc),
    .irq_out      (irq_out),
    .instr_count  (instr_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rst, input logic stl, input logic [2:0] src,
                       input logic bt, input logic [15:0] imm, input logic [25:0] tgt,
                       input logic [31:0] rs, input logic irq);
    reset = rst; stall = stl; pc_src = src; branch_taken = bt;
    imm16 = imm; target26 = tgt; rs_data = rs; irq_in = irq;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 16'h0, 26'h0, 32'h0, 0);
    tick();
    chk("rst_pc", pc, 32'h8000_0000);
    chk("rst_cnt", instr_count, 32'd0);
    chk("rst_irq", {31'd0, irq_out}, 32'd0);
    chk("rst_pc4", pc_plus4, 32'h8000_0004);

    drive(0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 0);
    tick(); chk("seq1", pc, 32'h8000_0004);
    tick(); chk("seq2", pc, 32'h8000_0008);
    tick(); chk("seq3", pc, 32'h8000_000C);
    chk("seq_cnt", instr_count, 32'd3);

    drive(0, 0, 3, 0, 16'h0, 26'h0, 32'h0000_0100, 0); tick();
    chk("jr_100", pc, 32'h0000_0100);
    drive(0, 0, 1, 1, 16'hFFFE, 26'h0, 32'h0, 0);
    chk("br_save", save_pc, 32'h0000_0104);
    tick();
    chk("br_taken", pc, 32'h0000_00FC);
    chk("br_cnt", instr_count, 32'd5);

    drive(0, 0, 3, 0, 16'h0, 26'h0, 32'h0000_0100, 0); tick();
    drive(0, 0, 1, 0, 16'hFFFE, 26'h0, 32'h0, 0); tick();
    chk("br_not", pc, 32'h0000_0104);

    drive(0, 0, 3, 0, 16'h0, 26'h0, 32'h8000_0040, 0); tick();
    drive(0, 0, 2, 0, 16'h0, 26'h000_0010, 32'h0, 0); tick();
    chk("j_kern", pc, 32'h8000_0040);
    chk("j_cnt", instr_count, 32'd9);

    drive(0, 0, 3, 0, 16'h0, 26'h0, 32'h0000_0200, 0); tick();
    chk("jr_user", pc, 32'h0000_0200);

    // Stay at 0x200 while the request pulse is latched.
    drive(0, 0, 3, 0, 16'h0, 26'h0, 32'h0000_0200, 1);
    chk("irq_lat0", {31'd0, irq_out}, 32'd0);
    tick();
    drive(0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 0);
    chk("irq_lat1", {31'd0, irq_out}, 32'd1);
    drive(0, 0, 4, 0, 16'h0, 26'h0, 32'h0, 0);
    chk("irq_save", save_pc, 32'h0000_0200);
    tick();
    chk("irq_vec", pc, 32'h8000_0004);
    chk("irq_cnt", instr_count, 32'd11);
    drive(0, 0, 3, 0, 16'h0, 26'h0, 32'h0000_0300, 0); tick();
    chk("irq_clr", {31'd0, irq_out}, 32'd0);

    drive(0, 0, 3, 0, 16'h0, 26'h0, 32'h8000_0100, 0); tick();
    drive(0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 1); tick();
    chk("kern_mask1", {31'd0, irq_out}, 32'd0);
    tick();
    chk("kern_mask2", {31'd0, irq_out}, 32'd0);
    chk("kern_pc", pc, 32'h8000_0108);
    drive(0, 0, 3, 0, 16'h0, 26'h0, 32'h0000_0400, 0); tick();
    chk("pend_user", {31'd0, irq_out}, 32'd1);
    drive(0, 0, 4, 0, 16'h0, 26'h0, 32'h0, 0); tick();
    chk("cnt_16", instr_count, 32'd16);

    drive(0, 0, 3, 0, 16'h0, 26'h0, 32'h0000_0500, 0); tick();
    drive(0, 0, 3, 0, 16'h0, 26'h0, 32'h0000_0500, 1); tick();
    drive(0, 1, 2, 0, 16'h0, 26'h000_0010, 32'h0, 0);
    chk("stall_irq", {31'd0, irq_out}, 32'd0);
    tick();
    chk("stall_pc1", pc, 32'h0000_0500);
    tick();
    chk("stall_pc2", pc, 32'h0000_0500);
    chk("stall_cnt", instr_count, 32'd18);
    chk("stall_irq2", {31'd0, irq_out}, 32'd0);
    drive(0, 0, 2, 0, 16'h0, 26'h000_0010, 32'h0, 0);
    chk("unstall_irq", {31'd0, irq_out}, 32'd1);
    tick();
    chk("unstall_j", pc, 32'h0000_0040);
    chk("unstall_cnt", instr_count, 32'd19);
    drive(0, 0, 4, 0, 16'h0, 26'h0, 32'h0, 0); tick();

    drive(0, 0, 3, 0, 16'h0, 26'h0, 32'h0000_0010, 0); tick();
    drive(0, 0, 7, 0, 16'h0, 26'h0, 32'h0, 0);
    chk("exc_save", save_pc, 32'h0000_0014);
    tick();
    chk("exc_vec", pc, 32'h8000_0008);
    chk("exc_cnt", instr_count, 32'd20);

    // Branch sum carries into bit 31 but the user-mode bit must survive.
    drive(0, 0, 3, 0, 16'h0, 26'h0, 32'h7FFF_FFF8, 0); tick();
    drive(0, 0, 1, 1, 16'h0001, 26'h0, 32'h0, 0); tick();
    chk("br_carry", pc, 32'h0000_0000);
    drive(0, 0, 3, 0, 16'h0, 26'h0, 32'hFFFF_FFFC, 0); tick();
    chk("pc4_wrap", pc_plus4, 32'h0000_0000);
    chk("wrap_cnt", instr_count, 32'd23);

    drive(1, 1, 2, 0, 16'h0, 26'h0, 32'h0, 1); tick();
    chk("rst2_pc", pc, 32'h8000_0000);
    chk("rst2_cnt", instr_count, 32'd0);
    drive(0, 0, 3, 0, 16'h0, 26'h0, 32'h0000_0600, 0); tick();
    chk("rst2_pend", {31'd0, irq_out}, 32'd0);
    chk("rst2_pc_j", pc, 32'h0000_0600);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
